// File: rtl/csr_reg_pkg.sv
// ============================================================================
// Module      : csr_reg_pkg
// Description : Shared CSR definitions: address width, CSR addresses, mstatus
//               bit positions and small helpers for read/write value shaping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_reg_pkg;

    localparam int CSR_ADDR_WIDTH = 12;

    typedef logic [CSR_ADDR_WIDTH-1:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS   = 12'h300;
    localparam csr_addr_t CSR_MIE       = 12'h304;
    localparam csr_addr_t CSR_MTVEC     = 12'h305;
    localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
    localparam csr_addr_t CSR_MEPC      = 12'h341;
    localparam csr_addr_t CSR_MCAUSE    = 12'h342;
    localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
    localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
    localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
    localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
    localparam csr_addr_t CSR_CYCLE     = 12'hC00;
    localparam csr_addr_t CSR_CYCLEH    = 12'hC80;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    // Machine-only core: MPP is hardwired to M-mode (2'b11).
    localparam logic [31:0] MSTATUS_MPP_VALUE = 32'(2'b11) << MSTATUS_MPP_LSB;

    // Assemble the architectural mstatus view from its two stored bits.
    function automatic logic [31:0] mstatus_value(input logic mie, input logic mpie);
        logic [31:0] v;
        v                   = MSTATUS_MPP_VALUE;
        v[MSTATUS_MIE_BIT]  = mie;
        v[MSTATUS_MPIE_BIT] = mpie;
        return v;
    endfunction

    // Addresses that accept software writes (read-only aliases excluded).
    function automatic logic is_writable(input csr_addr_t addr);
        return addr inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
                            CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH,
                            CSR_MINSTRET, CSR_MINSTRETH};
    endfunction

    // Value a register would hold after a software write of wdata.
    function automatic logic [31:0] write_mask(input csr_addr_t addr, input logic [31:0] wdata);
        logic [31:0] v;
        case (addr)
            CSR_MSTATUS:         v = mstatus_value(wdata[MSTATUS_MIE_BIT], wdata[MSTATUS_MPIE_BIT]);
            CSR_MTVEC, CSR_MEPC: v = {wdata[31:2], 2'b00};
            default:             v = wdata;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_reg_if.sv
// ============================================================================
// Module      : csr_reg_if
// Description : Bus bundle between the pipeline and the CSR file.
//               slave  : the CSR file (csr_reg)
//               master : the pipeline / testbench driving it
//               Signals: read port (raddr/rdata), write port (we/waddr/wdata),
//               trap entry (trap/epc/cause), mret, retire, and registered
//               mtvec/mepc/mie outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_reg_if;
    import csr_reg_pkg::*;

    logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i;
    logic [31:0]               csr_rdata_o;
    logic                      csr_we_i;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i;
    logic [31:0]               csr_wdata_i;
    logic                      trap_i;
    logic [31:0]               trap_epc_i;
    logic [31:0]               trap_cause_i;
    logic                      mret_i;
    logic                      retire_i;
    logic [31:0]               mtvec_o;
    logic [31:0]               mepc_o;
    logic                      mie_o;

    modport slave (
        input  csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i,
               trap_i, trap_epc_i, trap_cause_i, mret_i, retire_i,
        output csr_rdata_o, mtvec_o, mepc_o, mie_o
    );

    modport master (
        output csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i,
               trap_i, trap_epc_i, trap_cause_i, mret_i, retire_i,
        input  csr_rdata_o, mtvec_o, mepc_o, mie_o
    );

endinterface

`default_nettype wire

// File: rtl/csr_counter64.sv
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit wrapping counter with independently writable halves.
//               clk_i/rst_n_i : clock, async active-low reset
//               inc_i         : add one this cycle
//               we_lo_i/we_hi_i, wdata_i : software write of a 32-bit half
//               value_o       : current 64-bit count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_counter64 (
    input  wire logic        clk_i,
    input  wire logic        rst_n_i,
    input  wire logic        inc_i,
    input  wire logic        we_lo_i,
    input  wire logic        we_hi_i,
    input  wire logic [31:0] wdata_i,
    output logic      [63:0] value_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_inc;
    logic [31:0] lo_d;
    logic [31:0] hi_d;

    // The increment (and its carry) is formed from the pre-write value, so a
    // written half simply replaces its slice while the other half keeps it.
    always_comb begin
        cnt_inc = cnt_q + 64'(inc_i);
        lo_d    = we_lo_i ? wdata_i : cnt_inc[31:0];
        hi_d    = we_hi_i ? wdata_i : cnt_inc[63:32];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 64'h0;
        end else begin
            cnt_q <= {hi_d, lo_d};
        end
    end

    assign value_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/csr_reg.sv
// ============================================================================
// Module      : csr_reg
// Description : Machine-mode CSR file: mstatus, mie, mtvec, mscratch, mepc,
//               mcause and the mcycle/minstret counters (with user cycle
//               aliases). Combinational read with write bypass, trap entry
//               and mret handling.
//               clk_i   : clock
//               rst_n_i : async active-low reset
//               bus     : csr_reg_if.slave (read/write ports, trap, mret,
//                         retire, registered mtvec/mepc/mie outputs)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_reg
    import csr_reg_pkg::*;
(
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    csr_reg_if.slave  bus
);

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;

    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [31:0] wdata_masked;
    logic [31:0] rdata;
    logic        bypass;

    function automatic logic we_hit(input logic we, input csr_addr_t waddr, input csr_addr_t addr);
        return we && (waddr == addr);
    endfunction

    assign wdata_masked = write_mask(bus.csr_waddr_i, bus.csr_wdata_i);

    // ---------------------------------------------------------------- counters
    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (1'b1),
        .we_lo_i (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MCYCLE)),
        .we_hi_i (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MCYCLEH)),
        .wdata_i (bus.csr_wdata_i),
        .value_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (bus.retire_i),
        .we_lo_i (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MINSTRET)),
        .we_hi_i (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MINSTRETH)),
        .wdata_i (bus.csr_wdata_i),
        .value_o (minstret)
    );

    // -------------------------------------------------------------- next state
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MIE))      mie_d      = wdata_masked;
        if (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MTVEC))    mtvec_d    = wdata_masked;
        if (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MSCRATCH)) mscratch_d = wdata_masked;
        if (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MEPC))     mepc_d     = wdata_masked;
        if (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MCAUSE))   mcause_d   = wdata_masked;

        // Trap/mret are evaluated last so they override software writes to
        // the registers they own; trap also outranks mret.
        if (bus.trap_i) begin
            mepc_d         = {bus.trap_epc_i[31:2], 2'b00};
            mcause_d       = bus.trap_cause_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (bus.mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (we_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MSTATUS)) begin
            mstatus_mie_d  = bus.csr_wdata_i[MSTATUS_MIE_BIT];
            mstatus_mpie_d = bus.csr_wdata_i[MSTATUS_MPIE_BIT];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= 32'h0;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    // -------------------------------------------------------------- read port
    // Bypass is suppressed while reset is asserted so the read port shows
    // the reset state rather than a write that will never land.
    assign bypass = rst_n_i && bus.csr_we_i && (bus.csr_waddr_i == bus.csr_raddr_i)
                    && is_writable(bus.csr_waddr_i);

    always_comb begin
        rdata = 32'h0;
        case (bus.csr_raddr_i)
            CSR_MSTATUS:               rdata = mstatus_value(mstatus_mie_q, mstatus_mpie_q);
            CSR_MIE:                   rdata = mie_q;
            CSR_MTVEC:                 rdata = mtvec_q;
            CSR_MSCRATCH:              rdata = mscratch_q;
            CSR_MEPC:                  rdata = mepc_q;
            CSR_MCAUSE:                rdata = mcause_q;
            CSR_MCYCLE,  CSR_CYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:              rdata = minstret[31:0];
            CSR_MINSTRETH:             rdata = minstret[63:32];
            default:                   rdata = 32'h0;
        endcase
        if (bypass) begin
            rdata = wdata_masked;
        end
    end

    assign bus.csr_rdata_o = rdata;
    assign bus.mtvec_o     = mtvec_q;
    assign bus.mepc_o      = mepc_q;
    assign bus.mie_o       = mstatus_mie_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_reg.sv
// ============================================================================
// Module      : tb_csr_reg
// Description : Directed self-checking testbench for csr_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_reg;

    logic clk_i;
    logic rst_n_i;
    int   n_checks;
    int   n_fail;

    csr_reg_if bus ();

    csr_reg dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive the read address, let the combinational path settle, compare.
    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus.csr_raddr_i = addr;
        #1;
        check(tag, bus.csr_rdata_o, exp);
    endtask

    task automatic wr_set(input logic [11:0] addr, input logic [31:0] data);
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = addr;
        bus.csr_wdata_i = data;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_n_i          = 1'b0;
        bus.csr_raddr_i  = 12'h0;
        bus.csr_we_i     = 1'b0;
        bus.csr_waddr_i  = 12'h0;
        bus.csr_wdata_i  = 32'h0;
        bus.trap_i       = 1'b0;
        bus.trap_epc_i   = 32'h0;
        bus.trap_cause_i = 32'h0;
        bus.mret_i       = 1'b0;
        bus.retire_i     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_mtvec_o", bus.mtvec_o, 32'h0);
        check("rst_mepc_o",  bus.mepc_o,  32'h0);
        check("rst_mie_o",   32'(bus.mie_o), 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mcycle",  12'hB00, 32'h0);

        // Release, 5 clocks -> mcycle 5, minstret 0
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rd("mcycle_5",   12'hB00, 32'd5);
        rd("minstret_0", 12'hB02, 32'd0);
        rd("cycle_5",    12'hC00, 32'd5);

        @(negedge clk_i);
        rd("unimpl_rd", 12'h123, 32'h0);

        // mscratch write with same-cycle bypass
        @(negedge clk_i);
        wr_set(12'h340, 32'h0000_1234);
        rd("mscratch_bypass", 12'h340, 32'h0000_1234);
        @(posedge clk_i); #1;
        bus.csr_we_i = 1'b0;
        rd("mscratch_reg", 12'h340, 32'h0000_1234);

        // Counter carry: mcycleh=0, then mcycle=FFFF_FFFF
        @(negedge clk_i);
        wr_set(12'hB80, 32'h0);
        @(posedge clk_i); #1;
        wr_set(12'hB00, 32'hFFFF_FFFF);
        @(posedge clk_i); #1;
        bus.csr_we_i = 1'b0;
        rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_pre",    12'hB80, 32'h0);
        @(posedge clk_i); #1;
        rd("mcycle_wrap",  12'hB00, 32'h0);
        rd("mcycleh_carry", 12'hB80, 32'h1);

        // Write to read-only alias is ignored
        @(negedge clk_i);
        wr_set(12'hC80, 32'h55);
        @(posedge clk_i); #1;
        bus.csr_we_i = 1'b0;
        rd("cycleh_ro", 12'hB80, 32'h1);

        // minstret counts retires only
        @(negedge clk_i);
        bus.retire_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        bus.retire_i = 1'b0;
        rd("minstret_3", 12'hB02, 32'd3);

        // mie register
        @(negedge clk_i);
        wr_set(12'h304, 32'h0000_0888);
        @(posedge clk_i); #1;
        bus.csr_we_i = 1'b0;
        rd("mie_reg", 12'h304, 32'h0000_0888);

        // mstatus: set MIE, bypass shows masked value
        @(negedge clk_i);
        wr_set(12'h300, 32'h0000_0008);
        rd("mstatus_bypass", 12'h300, 32'h0000_1808);
        @(posedge clk_i); #1;
        bus.csr_we_i = 1'b0;
        check("mie_o_set", 32'(bus.mie_o), 32'h1);

        // Trap entry
        @(negedge clk_i);
        bus.trap_i       = 1'b1;
        bus.trap_epc_i   = 32'h8000_0006;
        bus.trap_cause_i = 32'h8000_000B;
        @(posedge clk_i); #1;
        bus.trap_i = 1'b0;
        check("trap_mepc_o", bus.mepc_o, 32'h8000_0004);
        check("trap_mie_o",  32'(bus.mie_o), 32'h0);
        rd("trap_mcause",  12'h342, 32'h8000_000B);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);

        // mret
        @(negedge clk_i);
        bus.mret_i = 1'b1;
        @(posedge clk_i); #1;
        bus.mret_i = 1'b0;
        check("mret_mie_o", 32'(bus.mie_o), 32'h1);
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // trap + mret + mepc write in one cycle: trap wins
        @(negedge clk_i);
        bus.trap_i       = 1'b1;
        bus.mret_i       = 1'b1;
        bus.trap_epc_i   = 32'h2000_0003;
        bus.trap_cause_i = 32'h0000_0007;
        wr_set(12'h341, 32'h0000_0100);
        @(posedge clk_i); #1;
        bus.trap_i   = 1'b0;
        bus.mret_i   = 1'b0;
        bus.csr_we_i = 1'b0;
        check("prio_mepc_o", bus.mepc_o, 32'h2000_0000);
        check("prio_mie_o",  32'(bus.mie_o), 32'h0);
        rd("prio_mcause",  12'h342, 32'h0000_0007);
        rd("prio_mstatus", 12'h300, 32'h0000_1880);

        // mtvec: bypass on read port, not on mtvec_o
        @(negedge clk_i);
        wr_set(12'h305, 32'h0000_1003);
        rd("mtvec_bypass", 12'h305, 32'h0000_1000);
        check("mtvec_o_nobypass", bus.mtvec_o, 32'h0);
        @(posedge clk_i); #1;
        bus.csr_we_i = 1'b0;
        check("mtvec_o_reg", bus.mtvec_o, 32'h0000_1000);

        // Reset pulsed mid-cycle during an mtvec write
        @(negedge clk_i);
        wr_set(12'h305, 32'h0000_2000);
        #1;
        rst_n_i = 1'b0;
        #1;
        check("midrst_mtvec_o", bus.mtvec_o, 32'h0);
        check("midrst_mepc_o",  bus.mepc_o,  32'h0);
        rd("midrst_mcycle", 12'hB00, 32'h0);
        bus.csr_we_i = 1'b0;
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("postrst_mtvec_o", bus.mtvec_o, 32'h0);
        rd("postrst_mcycle", 12'hB00, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
